// File: rtl/addr_seq_pkg.sv
// Shared types and default strides for the address sequencer.
// State encoding and ia stride defaults live here.
package addr_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam int unsigned IY_DEF = 10;
   localparam int unsigned IC_DEF = 100;

endpackage

// File: rtl/addr_seq_ctrl_seq_cnt.sv
// Wrapping loop counter: counts 0..fin while en is high.
// wrap flags that the current value is the last one.
module seq_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] fin,
   output logic [W-1:0] data,
   output logic         wrap
);

   assign wrap = (data == fin);

   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (clr) begin
         data <= '0;
      end else if (en) begin
         data <= wrap ? '0 : data + 1'b1;
      end
   end

endmodule

// File: rtl/addr_seq_ctrl.sv
// Three-level loop address sequencer producing dense wa and strided ia.
// ia is built incrementally from row and plane base registers.
module addr_seq_ctrl
   import addr_seq_pkg::*;
#(
   parameter int W  = 4,
   parameter int IY = IY_DEF,
   parameter int IC = IC_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [W-1:0] cmd_x_fin,
   input  logic [W-1:0] cmd_y_fin,
   input  logic [W-1:0] cmd_c_fin,
   input  logic [31:0]  cmd_w_base,
   input  logic [31:0]  cmd_i_base,
   input  logic         abort,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  wa,
   output logic [31:0]  ia,
   output logic         out_last,
   output logic         busy,
   output logic         done
);

   state_t       state;
   logic [W-1:0] x_fin_q, y_fin_q, c_fin_q;
   logic [W-1:0] x_cnt, y_cnt, c_cnt;
   logic         x_wrap, y_wrap, c_wrap;
   logic [31:0]  row_base, plane_base;
   logic         accept, fire, step;

   assign accept = cmd_valid && cmd_ready;
   assign fire   = out_valid && out_ready;
   // Counters and addresses only move on a beat that is not being aborted
   assign step   = fire && !abort;

   assign out_last = out_valid
                  && (x_cnt == x_fin_q)
                  && (y_cnt == y_fin_q)
                  && (c_cnt == c_fin_q);

   seq_cnt #(.W(W)) u_x (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (step),
      .fin  (x_fin_q),
      .data (x_cnt),
      .wrap (x_wrap)
   );

   seq_cnt #(.W(W)) u_y (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (step && x_wrap),
      .fin  (y_fin_q),
      .data (y_cnt),
      .wrap (y_wrap)
   );

   seq_cnt #(.W(W)) u_c (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (step && x_wrap && y_wrap),
      .fin  (c_fin_q),
      .data (c_cnt),
      .wrap (c_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         x_fin_q   <= '0;
         y_fin_q   <= '0;
         c_fin_q   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  state     <= S_RUN;
                  cmd_ready <= 1'b0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  x_fin_q   <= cmd_x_fin;
                  y_fin_q   <= cmd_y_fin;
                  c_fin_q   <= cmd_c_fin;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (fire && out_last) begin
                  state     <= S_DONE;
                  out_valid <= 1'b0;
                  done      <= 1'b1;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wa         <= '0;
         ia         <= '0;
         row_base   <= '0;
         plane_base <= '0;
      end else if (accept) begin
         wa         <= cmd_w_base;
         ia         <= cmd_i_base;
         row_base   <= cmd_i_base;
         plane_base <= cmd_i_base;
      end else if (step && !out_last) begin
         wa <= wa + 32'd1;
         if (!x_wrap) begin
            ia <= ia + 32'd1;
         end else if (!y_wrap) begin
            row_base <= row_base + 32'(IY);
            ia       <= row_base + 32'(IY);
         end else begin
            plane_base <= plane_base + 32'(IC);
            row_base   <= plane_base + 32'(IC);
            ia         <= plane_base + 32'(IC);
         end
      end
   end

   logic unused_c_wrap;
   assign unused_c_wrap = c_wrap;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed self-checking bench for addr_seq_ctrl.
// Expected addresses come from a straightforward loop model.
module tb_addr_seq_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [W-1:0] cmd_x_fin, cmd_y_fin, cmd_c_fin;
   logic [31:0]  cmd_w_base, cmd_i_base;
   logic         abort;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  wa, ia;
   logic         out_last, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   addr_seq_ctrl #(.W(W), .IY(10), .IC(100)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_x_fin  (cmd_x_fin),
      .cmd_y_fin  (cmd_y_fin),
      .cmd_c_fin  (cmd_c_fin),
      .cmd_w_base (cmd_w_base),
      .cmd_i_base (cmd_i_base),
      .abort      (abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .wa         (wa),
      .ia         (ia),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int xf, input int yf, input int cf,
                        input logic [31:0] wb, input logic [31:0] ib);
      cmd_x_fin  = W'(xf);
      cmd_y_fin  = W'(yf);
      cmd_c_fin  = W'(cf);
      cmd_w_base = wb;
      cmd_i_base = ib;
      cmd_valid  = 1'b1;
      chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid  = 1'b0;
      cmd_w_base = 32'hDEAD_BEEF;
      cmd_i_base = 32'hDEAD_BEEF;
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("cmd_ready_run", {31'd0, cmd_ready}, 32'd0);
   endtask

   task automatic run_job(input int xf, input int yf, input int cf,
                          input logic [31:0] wb, input logic [31:0] ib,
                          input bit toggle);
      int beat;
      logic [31:0] ew, ei;
      logic        el;
      beat = 0;
      issue(xf, yf, cf, wb, ib);
      for (int c = 0; c <= cf; c++) begin
         for (int y = 0; y <= yf; y++) begin
            for (int x = 0; x <= xf; x++) begin
               ew = wb + 32'(beat);
               ei = ib + 32'(c * 100 + y * 10 + x);
               el = (x == xf) && (y == yf) && (c == cf);
               chk("valid", {31'd0, out_valid}, 32'd1);
               chk("wa", wa, ew);
               chk("ia", ia, ei);
               chk("last", {31'd0, out_last}, {31'd0, el});
               if (toggle && (beat % 2 == 0)) begin
                  out_ready = 1'b0;
                  tick();
                  chk("hold_valid", {31'd0, out_valid}, 32'd1);
                  chk("hold_wa", wa, ew);
                  chk("hold_ia", ia, ei);
                  chk("hold_last", {31'd0, out_last}, {31'd0, el});
                  out_ready = 1'b1;
               end
               tick();
               beat++;
            end
         end
      end
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("valid_in_done", {31'd0, out_valid}, 32'd0);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      tick();
      chk("done_clear", {31'd0, done}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_x_fin  = '0;
      cmd_y_fin  = '0;
      cmd_c_fin  = '0;
      cmd_w_base = '0;
      cmd_i_base = '0;
      abort      = 1'b0;
      out_ready  = 1'b1;
      tick();
      tick();
      chk_idle("reset");
      chk("reset_wa", wa, 32'd0);
      chk("reset_ia", ia, 32'd0);
      chk("reset_last", {31'd0, out_last}, 32'd0);
      rst = 1'b0;
      tick();

      run_job(2, 2, 1, 32'd0, 32'd0, 1'b0);
      run_job(2, 2, 1, 32'd0, 32'd0, 1'b1);
      run_job(0, 0, 0, 32'hFFFF_FFFF, 32'd5, 1'b0);
      run_job(1, 0, 0, 32'hFFFF_FFFF, 32'd0, 1'b0);

      // abort while beat 4 is presented
      issue(2, 2, 1, 32'd0, 32'd0);
      tick();
      tick();
      tick();
      chk("abort_beat4_wa", wa, 32'd3);
      chk("abort_beat4_ia", ia, 32'd10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("abort");
      tick();
      chk("abort_no_done", {31'd0, done}, 32'd0);
      run_job(2, 2, 1, 32'd64, 32'd7, 1'b0);

      // reset mid-run
      issue(2, 2, 1, 32'd100, 32'd200);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_idle("rst_mid");
      chk("rst_mid_wa", wa, 32'd0);
      chk("rst_mid_ia", ia, 32'd0);
      chk("rst_mid_last", {31'd0, out_last}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_after_done", {31'd0, done}, 32'd0);

      // abort coinciding with the final beat
      issue(1, 0, 0, 32'd0, 32'd50);
      tick();
      chk("lastab_last", {31'd0, out_last}, 32'd1);
      chk("lastab_ia", ia, 32'd51);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("lastab");
      tick();
      chk("lastab_no_done", {31'd0, done}, 32'd0);

      // abort in IDLE is ignored
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("idle_abort");
      run_job(0, 1, 1, 32'd0, 32'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/addr_seq_ctrl.md
ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- W, 4: loop counter width, x/y/c.
- IY, 10: ia stride per y step.
- IC, 100: ia stride per c step.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  job command offered.
- cmd_ready  out  1  job command accepted when high with cmd_valid.
- cmd_x_fin  in  W  last x index, inclusive.
- cmd_y_fin  in  W  last y index, inclusive.
- cmd_c_fin  in  W  last c index, inclusive.
- cmd_w_base  in  32  wa start address.
- cmd_i_base  in  32  ia start address.
- abort  in  1  cancel the current job.
- out_valid  out  1  wa/ia beat presented.
- out_ready  in  1  consumer accepts the beat.
- wa  out  32  weight address.
- ia  out  32  input address.
- out_last  out  1  final beat of the job.
- busy  out  1  job in progress, RUN or DONE.
- done  out  1  one-cycle pulse on job completion.

Function
REQ-003 FSM states SHALL be IDLE, RUN and DONE. cmd_ready=1 only in IDLE. out_valid=1 only in RUN.
REQ-004 IDLE->RUN when cmd_valid&&cmd_ready. All cmd_* fields SHALL be latched on that edge. First out_valid SHALL appear the next cycle, with x=y=c=0.
REQ-005 A beat completes only on out_valid&&out_ready. With out_ready=0, wa/ia/out_last and all counters SHALL hold.
REQ-006 Loop order: x innermost, then y, then c, each counting 0..fin inclusive. A job SHALL emit exactly (x_fin+1)*(y_fin+1)*(c_fin+1) beats.
REQ-007 wa SHALL be w_base + beat index (dense, +1 per beat, including at row and plane wraps).
REQ-008 ia SHALL be i_base + c*IC + y*IY + x.
REQ-009 ia SHALL be computed incrementally from row-base and plane-base registers, with no multipliers.
REQ-010 All address arithmetic SHALL be modulo 2^32 and wrap silently.
REQ-011 out_last SHALL be 1 exactly when x=x_fin, y=y_fin and c=c_fin in RUN.
REQ-012 When the out_last beat completes, the FSM SHALL go RUN->DONE. done=1 for exactly one cycle in DONE, then the FSM returns to IDLE.
REQ-013 Minimum spacing between accepted commands SHALL be total beats + 2 cycles.
REQ-014 fin=0 on any loop is legal. All fins=0 yields one beat with out_last=1.
REQ-015 abort=1 in RUN or DONE SHALL force IDLE next cycle, with no done pulse and out_valid=0. abort in IDLE SHALL be ignored.
REQ-016 abort coinciding with completion of the last beat: abort SHALL win, with no done pulse.
REQ-017 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.

Reset
REQ-018 While rst=1, on each clk edge: state=IDLE; cmd_ready=1 from the next cycle; out_valid, out_last, done and busy=0; wa, ia and all counters=0.
REQ-019 rst SHALL take priority over abort, cmd_valid and out_ready. A job in progress when rst asserts SHALL be discarded without a done pulse.

Structure
REQ-020 Package addr_seq_pkg SHALL hold the state enum and the default IY/IC constants.
REQ-021 Sub-module seq_cnt SHALL be instantiated three times.
- Ports: clk, rst, clr, en, fin, data, wrap.
- Behaviour: counts 0..fin when en is high; wrap=(data==fin).

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- x/y/c fin=2/2/1, bases 0/0, out_ready=1 -> 18 beats; wa 0..17; ia sequence 0,1,2,10,11,12,20,21,22,100,...,122; out_last on beat 18 only; done 1 cycle later.
- Same job, out_ready toggling 1/0 -> identical beat sequence; outputs held while out_ready=0.
- All fins=0, w_base=0xFFFFFFFF, i_base=5 -> single beat wa=0xFFFFFFFF, ia=5, out_last=1.
- x_fin=1, y_fin=0, c_fin=0, w_base=0xFFFFFFFF -> beat 2 wa wraps to 0.
- abort asserted on beat 4 of the 18-beat job -> IDLE next cycle; no done; next command accepted and starts at x=y=c=0.
- rst mid-RUN, then abort coinciding with the final beat -> no done in either case; reset values per REQ-018.
